// File: rtl/dir_step_counter_pkg.sv
// Shared definitions for the dir_step_counter block: FSM encoding,
// direction constants and a prescaler width helper.
package dir_step_counter_pkg;

  // Run/stop control states
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Values of the dir input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler register width; at least one bit even when DIV == 1
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dir_step_counter_step_prescaler.sv
// step_prescaler: counts 0..DIV-1 while enabled and flags the last
// count as a step. Clearing or disabling returns it to 0, so a fresh
// enable always waits the full DIV cycles before the first step.
module step_prescaler
  import dir_step_counter_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int            PW   = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] q;

  // Phase counter: held at 0 when cleared or disabled, wraps after LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr || !en) begin
      q <= '0;
    end else if (q == LAST) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign step = en && !clr && (q == LAST);

endmodule

// File: rtl/mux2_n.sv
// Generic n-bit 2:1 multiplexer: y = sel ? i1 : i0.
module mux2_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? i1 : i0;

endmodule

// File: rtl/dir_step_counter.sv
// dir_step_counter: direction-controlled modulo up/down counter with a
// built-in prescaler and a run/stop FSM.
// Optional feature: define DIR_STEP_COUNTER_SATURATE_EN to hold at the
// limits instead of wrapping (tick and tc still pulse on the blocked step).
//
// Output protocol: tick acts as a valid strobe for cnt. It is high for
// exactly the one cycle in which cnt first shows a stepped value; there is
// no ready/backpressure, so the consumer must take cnt in that cycle.
// tc is qualified by tick and marks a wrap (or saturation). running
// mirrors the FSM state (1 = RUN).
module dir_step_counter
  import dir_step_counter_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int MAX_VAL = 9,
  parameter int DIV     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            dir,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  output logic [SIZE-1:0] cnt,
  output logic            tick,
  output logic            tc,
  output logic            running
);

  localparam logic [SIZE-1:0] MAX_C = SIZE'(MAX_VAL);

  state_t          state;
  state_t          state_next;
  logic            presc_en;
  logic            step;
  logic            at_limit;
  logic [SIZE-1:0] inc_val;
  logic [SIZE-1:0] dec_val;
  logic [SIZE-1:0] next_val;
  logic [SIZE-1:0] load_clamped;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: run level moves between STOP and RUN
  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: if (run)  state_next = ST_RUN;
      ST_RUN:  if (!run) state_next = ST_STOP;
      default: state_next = ST_STOP;
    endcase
  end

  assign running = (state == ST_RUN);

  // Prescaler only advances while in RUN with run still high; leaving RUN
  // clears it and drops any step that would have landed this cycle.
  assign presc_en = (state == ST_RUN) && run;

  step_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (presc_en),
    .step  (step)
  );

  // Limit reached in the current direction
  assign at_limit = (dir == DIR_UP) ? (cnt == MAX_C) : (cnt == '0);

  // Candidate values computed with explicit limit compares, never relying
  // on natural 2^SIZE overflow.
  always_comb begin
    inc_val = cnt + 1'b1;
    dec_val = cnt - 1'b1;
`ifdef DIR_STEP_COUNTER_SATURATE_EN
    if (cnt == MAX_C) inc_val = MAX_C;
    if (cnt == '0)    dec_val = '0;
`else
    if (cnt == MAX_C) inc_val = '0;
    if (cnt == '0)    dec_val = MAX_C;
`endif
  end

  mux2_n #(
    .N (SIZE)
  ) u_sel (
    .i0  (dec_val),
    .i1  (inc_val),
    .sel (dir),
    .y   (next_val)
  );

  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  // Count register with load priority over stepping; tick/tc are pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (load) begin
      cnt  <= load_clamped;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (step) begin
      cnt  <= next_val;
      tick <= 1'b1;
      tc   <= at_limit;
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dir_step_counter.sv
// Bench for dir_step_counter: directed scenarios plus random stimulus,
// checked cycle by cycle against a behavioural model via an expected queue.
module tb_dir_step_counter;

  localparam int SIZE    = 4;
  localparam int MAX_VAL = 9;
  localparam int DIV     = 3;
  localparam int W       = SIZE + 3;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic            dir;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] cnt;
  logic            tick;
  logic            tc;
  logic            running;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Model state: count value, cycles of RUN seen since last clear, FSM
  int m_cnt;
  int m_phase;
  bit m_run;

  bit rnd_run;

  dir_step_counter #(
    .SIZE    (SIZE),
    .MAX_VAL (MAX_VAL),
    .DIV     (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .tick     (tick),
    .tc       (tc),
    .running  (running)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_run   = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs and push the state expected after the edge.
  task automatic drive(input bit r, input bit d, input bit l, input int lv);
    int nx;
    bit tk;
    bit t;
    logic [SIZE-1:0] nx_v;
    @(negedge clk);
    #1;
    run      = r;
    dir      = d;
    load     = l;
    load_val = SIZE'(lv);
    nx = m_cnt;
    tk = 1'b0;
    t  = 1'b0;
    if (l) begin
      nx      = (lv > MAX_VAL) ? MAX_VAL : lv;
      m_phase = 0;
    end else if (m_run && r) begin
      if (m_phase == DIV - 1) begin
        m_phase = 0;
        tk      = 1'b1;
        if (d) begin
          if (m_cnt == MAX_VAL) begin
            t = 1'b1;
`ifdef DIR_STEP_COUNTER_SATURATE_EN
            nx = MAX_VAL;
`else
            nx = 0;
`endif
          end else begin
            nx = m_cnt + 1;
          end
        end else begin
          if (m_cnt == 0) begin
            t = 1'b1;
`ifdef DIR_STEP_COUNTER_SATURATE_EN
            nx = 0;
`else
            nx = MAX_VAL;
`endif
          end else begin
            nx = m_cnt - 1;
          end
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end else begin
      m_phase = 0;
    end
    m_run = r;
    m_cnt = nx;
    nx_v  = SIZE'(nx);
    exp_q.push_back({m_run, tk, t, nx_v});
  endtask

  task automatic run_cycles(input int n, input bit d);
    for (int i = 0; i < n; i++) drive(1'b1, d, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [W-1:0] got;
    got = {running, tick, tc, cnt};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: got running/tick/tc/cnt=%b expected %b", name, got, {W{1'b0}});
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    run   = 1'b0;
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (rst_n && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {running, tick, tc, cnt};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_out @%0t: got running=%b tick=%b tc=%b cnt=%0d expected running=%b tick=%b tc=%b cnt=%0d",
                 $time, got[W-1], got[W-2], got[W-3], got[SIZE-1:0],
                 e[W-1], e[W-2], e[W-3], e[SIZE-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Up with wrap from 8
    drive(1'b0, 1'b1, 1'b1, 8);
    run_cycles(10, 1'b1);

    // Down with wrap from 1 (load while running)
    drive(1'b1, 1'b0, 1'b1, 1);
    run_cycles(13, 1'b0);

    // Load of an over-range value exactly on a step cycle
    for (int i = 0; i < DIV + 2 && m_phase != DIV - 1; i++) drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 13);
    run_cycles(7, 1'b1);

    // Load while stopped
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b0, 0);

    // Stop one cycle before the step, then restart
    run_cycles(2, 1'b1);
    for (int i = 0; i < DIV + 2 && m_phase != 1; i++) drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    run_cycles(8, 1'b1);

    // Reset mid-run at cnt=5, then restart
    drive(1'b1, 1'b1, 1'b1, 5);
    run_cycles(2, 1'b1);
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 0);
    run_cycles(7, 1'b1);

    // Behaviour at the upper limit, then turning down
    drive(1'b1, 1'b1, 1'b1, 9);
    run_cycles(7, 1'b1);
    run_cycles(4, 1'b0);

    // Random traffic; run only changes on non-load cycles
    rnd_run = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit l;
      l = ($urandom_range(0, 15) == 0);
      if (!l && $urandom_range(0, 7) == 0) rnd_run = !rnd_run;
      drive(rnd_run, 1'($urandom_range(0, 1)), l, int'($urandom_range(0, 15)));
    end

    drive(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
